// File: rtl/uart_pkg.sv
// Shared definitions for the minisoc UART TX slave: register offsets,
// STATUS/CTRL bit positions and the serialiser state encoding.
package uart_pkg;

    // Register select values, taken from addr[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/uart_tx_slave_if.sv
// Data-bus port of the UART TX slave plus its serial/interrupt outputs and
// a serialiser state view for observation.
interface uart_tx_slave_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    import uart_pkg::*;

    // Handshake: a request is accepted on any cycle where req & addr_ok; exactly
    // one data_ok pulse follows on the next cycle, carrying rdata for reads
    // (rdata is 0 whenever data_ok is low). addr_ok stays high outside reset.
    logic            req;
    logic            write;
    logic [DW/8-1:0] wstrb;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic            addr_ok;
    logic            data_ok;
    logic [DW-1:0]   rdata;
    logic            txd;
    logic            irq;
    tx_state_t       dbg_state;

    modport master (
        output req, write, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata, txd, irq, dbg_state
    );

    modport slave (
        input  req, write, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata, txd, irq, dbg_state
    );

endinterface

// File: rtl/uart_tx_slave_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full and pop
// is ignored when empty. Head entry is visible on rdata without a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_slave.sv
// Transmit-only 8N1 UART on the minisoc data bus: register file, TX FIFO and
// a serialiser whose bit time is BAUDDIV+1 clocks.
module uart_tx_slave
    import uart_pkg::*;
#(
    parameter int          AW          = 16,
    parameter int          DW          = 32,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input logic             clk,
    input logic             rst,
    uart_tx_slave_if.slave  uart
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             accept;
    logic             wr;
    logic [1:0]       reg_sel;
    logic [15:0]      baud_div;
    logic [1:0]       ctrl;
    logic             overflow;
    logic             data_ok_q;
    logic [DW-1:0]    rdata_q;
    logic [DW-1:0]    read_val;
    logic [3:0]       cnt_disp;
    logic             wr_txdata;
    logic             ovf_set;
    logic             ovf_clr;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_head;

    tx_state_t        state, state_d;
    logic [15:0]      bit_cnt, bit_cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       shift, shift_d;
    logic             txd_q, txd_d;
    logic             irq_q;

    logic             unused_bits;
    assign unused_bits = ^{uart.addr[AW-1:4], uart.addr[1:0], uart.wdata[DW-1:16], uart.wstrb[DW/8-1:2]};

    assign uart.addr_ok   = 1'b1;
    assign accept         = uart.req & uart.addr_ok;
    assign wr             = accept & uart.write;
    assign reg_sel        = uart.addr[3:2];
    assign uart.data_ok   = data_ok_q;
    assign uart.rdata     = rdata_q;
    assign uart.txd       = txd_q;
    assign uart.irq       = irq_q;
    assign uart.dbg_state = state;

    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost
    assign wr_txdata = wr & (reg_sel == REG_TXDATA) & uart.wstrb[0];
    assign fifo_push = wr_txdata & ~fifo_full;
    assign ovf_set   = wr_txdata & fifo_full;
    assign ovf_clr   = wr & (reg_sel == REG_STATUS) & uart.wstrb[0] & uart.wdata[STAT_OVF];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (uart.wdata[7:0]),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        cnt_disp = (32'(fifo_count) > 32'd15) ? 4'd15 : 4'(fifo_count);
        read_val = '0;
        case (reg_sel)
            REG_STATUS: begin
                read_val[STAT_FULL]          = fifo_full;
                read_val[STAT_EMPTY]         = fifo_empty;
                read_val[STAT_BUSY]          = (state != IDLE);
                read_val[STAT_OVF]           = overflow;
                read_val[STAT_CNT_LSB +: 4]  = cnt_disp;
            end
            REG_BAUDDIV: read_val[15:0] = baud_div;
            REG_CTRL:    read_val[1:0]  = ctrl;
            default:     read_val       = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_div  <= DEFAULT_DIV;
            ctrl      <= '0;
            overflow  <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (wr && reg_sel == REG_BAUDDIV) begin
                if (uart.wstrb[0]) baud_div[7:0]  <= uart.wdata[7:0];
                if (uart.wstrb[1]) baud_div[15:8] <= uart.wdata[15:8];
            end
            if (wr && reg_sel == REG_CTRL && uart.wstrb[0]) ctrl <= uart.wdata[1:0];
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            data_ok_q <= accept;
            rdata_q   <= (accept && !uart.write) ? read_val : '0;
        end
    end

    // Bit counter reloads from the live BAUDDIV at every bit boundary
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl[CTRL_TX_EN] && !fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_head;
                    bit_cnt_d = baud_div;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_cnt == '0) begin
                    bit_cnt_d = baud_div;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt - 16'd1;
                end
            end
            DATA: begin
                if (bit_cnt == '0) begin
                    bit_cnt_d = baud_div;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        shift_d   = {1'b0, shift[7:1]};
                    end
                end else begin
                    bit_cnt_d = bit_cnt - 16'd1;
                end
            end
            STOP: begin
                if (bit_cnt == '0) state_d   = IDLE;
                else               bit_cnt_d = bit_cnt - 16'd1;
            end
            default: state_d = IDLE;
        endcase
        txd_d = (state_d == START) ? 1'b0 :
                (state_d == DATA)  ? shift_d[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd_q   <= 1'b1;
            irq_q   <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            txd_q   <= txd_d;
            irq_q   <= ctrl[CTRL_IRQ_EN] & fifo_empty & (state == IDLE);
        end
    end

endmodule
